// File: rtl/id_stage_fwd.sv
// MIPS decode stage for the logic/shift/immediate subset plus LW. It forwards operands
// from FWD_N sources, stalls on load-use hazards and registers the ID/EX payload.
module id_stage_fwd #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_N  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [31:0]             pc_i,
  input  logic [31:0]             inst_i,
  output logic [REG_AW-1:0]       reg1_addr_o,
  output logic [REG_AW-1:0]       reg2_addr_o,
  input  logic [DATA_W-1:0]       reg1_data_i,
  input  logic [DATA_W-1:0]       reg2_data_i,
  input  logic [FWD_N-1:0]        fwd_wreg_i,
  input  logic [FWD_N-1:0]        fwd_load_i,
  input  logic [FWD_N*REG_AW-1:0] fwd_wd_i,
  input  logic [FWD_N*DATA_W-1:0] fwd_wdata_i,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [7:0]              aluop_o,
  output logic [2:0]              alusel_o,
  output logic [DATA_W-1:0]       reg1_o,
  output logic [DATA_W-1:0]       reg2_o,
  output logic [REG_AW-1:0]       wd_o,
  output logic                    wreg_o,
  output logic [31:0]             pc_o,
  output logic                    inv_inst_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_AND = 6'h24, F_OR = 6'h25,
                         F_XOR = 6'h26, F_NOR = 6'h27;

  logic [5:0]  opcode, funct;
  logic [4:0]  sa;
  logic [15:0] imm16;
  logic [REG_AW-1:0] rs, rt, rd;

  assign opcode = inst_i[31:26];
  assign funct  = inst_i[5:0];
  assign sa     = inst_i[10:6];
  assign imm16  = inst_i[15:0];
  assign rs     = REG_AW'(inst_i[25:21]);
  assign rt     = REG_AW'(inst_i[20:16]);
  assign rd     = REG_AW'(inst_i[15:11]);

  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic              re1, re2, dec_wreg, dec_inv;
  logic [DATA_W-1:0] imm1, imm2;
  logic [REG_AW-1:0] dec_wd;

  function automatic logic [7:0] shift_aluop(input logic [1:0] kind);
    case (kind)
      2'b10:   shift_aluop = 8'h02;
      2'b11:   shift_aluop = 8'h03;
      default: shift_aluop = 8'h7C;
    endcase
  endfunction

  // The all-zero word falls through with the default NOP fields and no invalid flag.
  always_comb begin
    dec_aluop  = 8'h00;
    dec_alusel = 3'b000;
    re1        = 1'b0;
    re2        = 1'b0;
    imm1       = '0;
    imm2       = '0;
    dec_wd     = '0;
    dec_wreg   = 1'b0;
    dec_inv    = 1'b0;
    if (inst_i != 32'h0) begin
      case (opcode)
        OP_SPECIAL: begin
          case (funct)
            F_OR, F_AND, F_XOR, F_NOR, F_SLLV, F_SRLV, F_SRAV: begin
              if (sa == 5'd0) begin
                dec_aluop  = funct[5] ? {2'b00, funct} : shift_aluop(funct[1:0]);
                dec_alusel = funct[5] ? 3'b001 : 3'b010;
                re1        = 1'b1;
                re2        = 1'b1;
                dec_wd     = rd;
                dec_wreg   = 1'b1;
              end else begin
                dec_inv = 1'b1;
              end
            end
            F_SLL, F_SRL, F_SRA: begin
              if (inst_i[25:21] == 5'd0) begin
                dec_aluop  = shift_aluop(funct[1:0]);
                dec_alusel = 3'b010;
                re2        = 1'b1;
                imm1       = DATA_W'(sa);
                dec_wd     = rd;
                dec_wreg   = 1'b1;
              end else begin
                dec_inv = 1'b1;
              end
            end
            default: dec_inv = 1'b1;
          endcase
        end
        OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
          dec_aluop  = (opcode == OP_ANDI) ? 8'h24 : (opcode == OP_XORI) ? 8'h26 : 8'h25;
          dec_alusel = 3'b001;
          re1        = 1'b1;
          imm2       = (opcode == OP_LUI) ? DATA_W'({imm16, 16'h0000}) : DATA_W'(imm16);
          dec_wd     = rt;
          dec_wreg   = 1'b1;
        end
        OP_LW: begin
          dec_aluop  = 8'hE3;
          dec_alusel = 3'b111;
          re1        = 1'b1;
          imm2       = DATA_W'($signed(imm16));
          dec_wd     = rt;
          dec_wreg   = 1'b1;
        end
        default: dec_inv = 1'b1;
      endcase
    end
  end

  // Returns {hazard, operand}; the youngest matching source wins, load or not.
  function automatic logic [DATA_W:0] resolve(input logic rd_en, input logic [REG_AW-1:0] addr,
                                              input logic [DATA_W-1:0] imm,
                                              input logic [DATA_W-1:0] rf_data);
    logic hit;
    hit     = 1'b0;
    resolve = {1'b0, imm};
    if (rd_en) begin
      if (addr == '0) begin
        resolve = '0;
      end else begin
        resolve = {1'b0, rf_data};
        for (int k = 0; k < FWD_N; k++) begin
          if (!hit && fwd_wreg_i[k] && fwd_wd_i[k*REG_AW +: REG_AW] == addr) begin
            hit     = 1'b1;
            resolve = {fwd_load_i[k], fwd_wdata_i[k*DATA_W +: DATA_W]};
          end
        end
      end
    end
  endfunction

  logic [DATA_W-1:0] op1, op2;
  logic              hz1, hz2, hazard, accept;

  assign {hz1, op1} = resolve(re1, rs, imm1, reg1_data_i);
  assign {hz2, op2} = resolve(re2, rt, imm2, reg2_data_i);
  assign hazard     = hz1 | hz2;
  assign in_ready_o = !rst && !flush_i && !hazard && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // ID/EX register: reset and flush insert a bubble, a consumed entry with nothing new also drains.
  always_ff @(posedge clk) begin
    if (rst || flush_i || (!accept && (!out_valid_o || out_ready_i))) begin
      out_valid_o <= 1'b0;
      aluop_o     <= 8'h00;
      alusel_o    <= 3'b000;
      reg1_o      <= '0;
      reg2_o      <= '0;
      wd_o        <= '0;
      wreg_o      <= 1'b0;
      pc_o        <= 32'h0;
      inv_inst_o  <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      aluop_o     <= dec_aluop;
      alusel_o    <= dec_alusel;
      reg1_o      <= op1;
      reg2_o      <= op2;
      wd_o        <= dec_wd;
      wreg_o      <= dec_wreg;
      pc_o        <= pc_i;
      inv_inst_o  <= dec_inv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (in_valid_i && hazard && !flush_i && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: expected ID/EX payloads are queued when an
// instruction is offered for acceptance and popped when the stage presents it.
module tb_id_stage_fwd;

  localparam logic [31:0] R1 = 32'h0000_F0F0;
  localparam logic [31:0] R2 = 32'h0000_2222;

  logic        clk = 1'b0;
  logic        rst, in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i, reg1_o, reg2_o, pc_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
  logic [1:0]  fwd_wreg_i, fwd_load_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic        wreg_o, inv_inst_o;
  logic [15:0] stall_cnt_o;

  always #5 clk = ~clk;

  id_stage_fwd dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .fwd_wreg_i(fwd_wreg_i),
    .fwd_load_i(fwd_load_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .inv_inst_o(inv_inst_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    in_valid_i = v;
    pc_i       = pc;
    inst_i     = inst;
  endtask

  task automatic setFwd(input int k, input logic w, input logic ld, input logic [4:0] wd,
                        input logic [31:0] d);
    fwd_wreg_i[k]         = w;
    fwd_load_i[k]         = ld;
    fwd_wd_i[k*5 +: 5]    = wd;
    fwd_wdata_i[k*32 +: 32] = d;
  endtask

  task automatic clearFwd();
    setFwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
    setFwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic pushExp(input logic [7:0] aluop, input logic [2:0] alusel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] pc, input logic inv);
    exp_t e;
    e.aluop = aluop; e.alusel = alusel; e.reg1 = r1; e.reg2 = r2;
    e.wd = wd; e.wreg = wreg; e.pc = pc; e.inv = inv;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkFields(input string step, input exp_t e);
    checkOutput({step, ".aluop"},  aluop_o,    e.aluop);
    checkOutput({step, ".alusel"}, alusel_o,   e.alusel);
    checkOutput({step, ".reg1"},   reg1_o,     e.reg1);
    checkOutput({step, ".reg2"},   reg2_o,     e.reg2);
    checkOutput({step, ".wd"},     wd_o,       e.wd);
    checkOutput({step, ".wreg"},   wreg_o,     e.wreg);
    checkOutput({step, ".pc"},     pc_o,       e.pc);
    checkOutput({step, ".inv"},    inv_inst_o, e.inv);
  endtask

  task automatic checkAccepted(input string step);
    checkOutput({step, ".valid"}, out_valid_o, 1'b1);
    checkOutput({step, ".sb_size"}, sb.size(), 1);
    if (sb.size() > 0) begin
      last_exp = sb.pop_front();
      checkFields(step, last_exp);
    end
  endtask

  task automatic checkHeld(input string step);
    checkOutput({step, ".valid"}, out_valid_o, 1'b1);
    checkFields(step, last_exp);
  endtask

  task automatic checkBubble(input string step);
    checkOutput({step, ".valid"}, out_valid_o, 1'b0);
    checkOutput({step, ".wreg"},  wreg_o,      1'b0);
    checkOutput({step, ".aluop"}, aluop_o,     8'h00);
    checkOutput({step, ".reg1"},  reg1_o,      32'h0);
    checkOutput({step, ".pc"},    pc_o,        32'h0);
  endtask

  // Bounds the run even if a step blocks unexpectedly.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    reg1_data_i = R1; reg2_data_i = R2;
    clearFwd();
    applyStimulus(1'b1, 32'h100, 32'h3401_1100);
    #1 checkOutput("rst.in_ready", in_ready_o, 1'b0);
    tick(); tick();
    checkBubble("rst");
    checkOutput("rst.stall", stall_cnt_o, 16'd0);
    rst = 1'b0;

    // ORI $1,$0,0x1100 into an empty pipe
    #1 checkOutput("ori.in_ready", in_ready_o, 1'b1);
    pushExp(8'h25, 3'b001, 32'h0, 32'h1100, 5'd1, 1'b1, 32'h100, 1'b0);
    tick(); checkAccepted("ori");

    // OR $3,$1,$2 with both sources matching: youngest wins
    setFwd(0, 1'b1, 1'b0, 5'd1, 32'd5);
    setFwd(1, 1'b1, 1'b0, 5'd1, 32'd7);
    applyStimulus(1'b1, 32'h104, 32'h0022_1825);
    #1 checkOutput("or.addr1", reg1_addr_o, 5'd1);
    checkOutput("or.addr2", reg2_addr_o, 5'd2);
    pushExp(8'h25, 3'b001, 32'd5, R2, 5'd3, 1'b1, 32'h104, 1'b0);
    tick(); checkAccepted("or_fwd0");

    setFwd(0, 1'b0, 1'b0, 5'd1, 32'd5);
    applyStimulus(1'b1, 32'h108, 32'h0022_1825);
    pushExp(8'h25, 3'b001, 32'd7, R2, 5'd3, 1'b1, 32'h108, 1'b0);
    tick(); checkAccepted("or_fwd1");

    // A source targeting $0 must not forward
    setFwd(0, 1'b1, 1'b0, 5'd0, 32'hDEAD);
    setFwd(1, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, 32'h10C, 32'h0002_1825);
    pushExp(8'h25, 3'b001, 32'h0, R2, 5'd3, 1'b1, 32'h10C, 1'b0);
    tick(); checkAccepted("or_r0");

    // Load-use: OR $5,$4,$4 behind an LW writing $4
    setFwd(0, 1'b1, 1'b1, 5'd4, 32'h1234);
    applyStimulus(1'b1, 32'h110, 32'h0084_2825);
    #1 checkOutput("lu.in_ready", in_ready_o, 1'b0);
    tick(); checkBubble("lu_stall");
    checkOutput("lu.stall", stall_cnt_o, 16'd1);

    setFwd(0, 1'b0, 1'b0, 5'd0, 32'h0);
    setFwd(1, 1'b1, 1'b0, 5'd4, 32'hABCD);
    #1 checkOutput("lu_go.in_ready", in_ready_o, 1'b1);
    pushExp(8'h25, 3'b001, 32'hABCD, 32'hABCD, 5'd5, 1'b1, 32'h110, 1'b0);
    tick(); checkAccepted("lu_go");

    // Backpressure for three cycles, then ANDI $6,$1,0xFF back to back
    clearFwd();
    out_ready_i = 1'b0;
    applyStimulus(1'b1, 32'h114, 32'h3026_00FF);
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("bp.in_ready", in_ready_o, 1'b0);
      tick(); checkHeld("bp_hold");
    end
    out_ready_i = 1'b1;
    #1 checkOutput("bp_rel.in_ready", in_ready_o, 1'b1);
    pushExp(8'h24, 3'b001, R1, 32'h0000_00FF, 5'd6, 1'b1, 32'h114, 1'b0);
    tick(); checkAccepted("bp_release");
    checkOutput("bp.stall", stall_cnt_o, 16'd1);

    // Flush beats a held entry and a pending XORI
    out_ready_i = 1'b0;
    flush_i = 1'b1;
    applyStimulus(1'b1, 32'h118, 32'h3847_0F0F);
    #1 checkOutput("flush.in_ready", in_ready_o, 1'b0);
    tick(); checkBubble("flush");
    flush_i = 1'b0;
    out_ready_i = 1'b1;

    pushExp(8'h26, 3'b001, R1, 32'h0000_0F0F, 5'd7, 1'b1, 32'h118, 1'b0);
    tick(); checkAccepted("xori");

    applyStimulus(1'b1, 32'h11C, 32'hFC00_0000);
    pushExp(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h11C, 1'b1);
    tick(); checkAccepted("inv_op");

    applyStimulus(1'b1, 32'h120, 32'h0022_1865);
    pushExp(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h120, 1'b1);
    tick(); checkAccepted("inv_sa");

    applyStimulus(1'b1, 32'h124, 32'h0003_1100);
    pushExp(8'h7C, 3'b010, 32'd4, R2, 5'd2, 1'b1, 32'h124, 1'b0);
    tick(); checkAccepted("sll");

    applyStimulus(1'b1, 32'h128, 32'h00C5_2007);
    pushExp(8'h03, 3'b010, R1, R2, 5'd4, 1'b1, 32'h128, 1'b0);
    tick(); checkAccepted("srav");

    applyStimulus(1'b1, 32'h12C, 32'h8D28_FFFC);
    pushExp(8'hE3, 3'b111, R1, 32'hFFFF_FFFC, 5'd8, 1'b1, 32'h12C, 1'b0);
    tick(); checkAccepted("lw");

    applyStimulus(1'b1, 32'h130, 32'h0000_0000);
    pushExp(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h130, 1'b0);
    tick(); checkAccepted("nop");

    applyStimulus(1'b1, 32'h134, 32'h3C01_1234);
    pushExp(8'h25, 3'b001, 32'h0, 32'h1234_0000, 5'd1, 1'b1, 32'h134, 1'b0);
    tick(); checkAccepted("lui");

    // Stall again, then reset in the middle of it
    setFwd(0, 1'b1, 1'b1, 5'd4, 32'h0);
    applyStimulus(1'b1, 32'h138, 32'h0084_2825);
    tick(); checkBubble("stall2");
    checkOutput("stall2.cnt", stall_cnt_o, 16'd2);
    rst = 1'b1;
    #1 checkOutput("rst2.in_ready", in_ready_o, 1'b0);
    tick(); checkBubble("rst2");
    checkOutput("rst2.stall", stall_cnt_o, 16'd0);
    checkOutput("rst2.inv", inv_inst_o, 1'b0);
    rst = 1'b0;
    clearFwd();
    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("end.sb_size", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
- Next-generation MIPS instruction-decode stage: decodes the logic/shift/immediate subset plus LW.
- Resolves operands with a parametrised number of forwarding sources, detects load-use hazards and stalls.
- Registers its outputs as the ID/EX pipeline register, with valid/ready backpressure and flush.
- Sits between the IF/ID register and EX; the upstream register holds inst_i while in_ready_o=0.

Parameters:
DATA_W, 32, register/data width
REG_AW, 5, register address width
FWD_N, 2, number of forwarding sources; index 0 = youngest (EX), highest priority
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid_i  in  1  inst_i/pc_i valid
in_ready_o  out  1  instruction accepted this cycle when in_valid_i&in_ready_o
pc_i  in  32  instruction address
inst_i  in  32  instruction word
reg1_addr_o  out  REG_AW  regfile port-1 address (combinational, = inst_i[25:21])
reg2_addr_o  out  REG_AW  regfile port-2 address (combinational, = inst_i[20:16])
reg1_data_i  in  DATA_W  regfile port-1 data (same cycle)
reg2_data_i  in  DATA_W  regfile port-2 data
fwd_wreg_i  in  FWD_N  source k writes a register
fwd_load_i  in  FWD_N  source k result not yet available (load in flight)
fwd_wd_i  in  FWD_N*REG_AW  source k destination, slice k
fwd_wdata_i  in  FWD_N*DATA_W  source k result, slice k
flush_i  in  1  kill the ID/EX contents
out_valid_o  out  1  registered outputs hold an instruction
out_ready_i  in  1  EX consumes when out_valid_o&out_ready_i
aluop_o  out  8  registered ALU op
alusel_o  out  3  registered result select
reg1_o  out  DATA_W  registered operand 1
reg2_o  out  DATA_W  registered operand 2
wd_o  out  REG_AW  registered destination
wreg_o  out  1  registered write enable
pc_o  out  32  registered pc
inv_inst_o  out  1  registered: accepted instruction was undecodable
stall_cnt_o  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst` is synchronous, active-high.
  - In reset: out_valid_o=0, aluop_o=8'h00, alusel_o=3'b000, reg1_o=reg2_o=0, wd_o=0, wreg_o=0, pc_o=0, inv_inst_o=0, stall_cnt_o=0.
  - in_ready_o=0 while rst=1.
- Decode (combinational on inst_i):
  - Register-register ops: OR/AND/XOR/NOR funct 25/24/26/27 → aluop 25/24/26/27h, alusel 001. SLLV/SRLV/SRAV funct 04/06/07 → aluop 7Ch/02h/03h, alusel 010. All require inst[10:6]=0, read rs and rt, wd=rd.
  - SLL/SRL/SRA funct 00/02/03 with inst[25:21]=0: read rt only; operand1 = zero-extended sa; wd=rd.
  - ORI/ANDI/XORI (op 0D/0C/0E): rs read; operand2 = zero-extended imm; wd=rt.
  - LUI (op 0F): rs read; operand2 = imm<<16; aluop OR.
  - LW (op 23): aluop E3h, alusel 111, rs read; operand2 = sign-extended imm; wd=rt.
  - All-zero word is NOP: valid, wreg=0.
  - Anything else: NOP fields, wreg=0, inv_inst=1.
- Operand resolution, per read port:
  - If not read: operand = immediate (as above).
  - Else if address=0: operand = 0; never forwarded, never a hazard.
  - Else the lowest-index k with fwd_wreg_i[k] and fwd_wd_i[k]==addr supplies fwd_wdata_i[k].
  - Else regfile data.
- Hazard: hazard=1 when a read port's selected source k has fwd_load_i[k]=1.
  - An older matching source does not clear a hazard raised by a younger one.
- Handshake:
  - in_ready_o = !rst & !flush_i & !hazard & (!out_valid_o | out_ready_i).
  - Accept cycle: output registers load the decoded fields; out_valid_o=1 next cycle. Latency 1 cycle.
  - No accept while out_valid_o & out_ready_i: out_valid_o←0 and all payload outputs ← NOP/zero (bubble).
  - No accept while out_valid_o & !out_ready_i: all outputs hold.
- flush_i: takes priority over accept. Next cycle out_valid_o=0 and payload ← bubble, regardless of out_ready_i.
- stall_cnt_o increments in every cycle with in_valid_i & hazard & !flush_i & !rst, saturating at all-ones.

Test Plan:
- ORI $1,$0,0x1100 accepted with empty pipe → next cycle out_valid_o=1, aluop 25h, alusel 001, reg1_o=0, reg2_o=0x1100, wd_o=1, wreg_o=1.
- OR $3,$1,$2 with fwd0 (wd=1, data=5) and fwd1 (wd=1, data=7) both wreg=1 → reg1_o=5; with only fwd1 matching → reg1_o=7; fwd to $0 with rs=0 → reg1_o=0.
- LW in EX (fwd_load_i[0]=1, wd=4), then ADD-type OR $5,$4,$4 → in_ready_o=0 for that cycle, stall_cnt_o +1, bubble emitted. When fwd_load_i drops and the result is on fwd1 (data 0xABCD) → accepted, reg1_o=reg2_o=0xABCD.
- out_ready_i=0 for 3 cycles with out_valid_o=1 → outputs stable, in_ready_o=0. Raising out_ready_i with a new instruction → back-to-back accept, no bubble.
- flush_i during an accept attempt → no accept; next cycle out_valid_o=0, wreg_o=0. rst asserted mid-stall → all outputs reach reset values next cycle, stall_cnt_o=0.
- Inst 0xFC000000 → inv_inst_o=1, wreg_o=0. SLL $2,$3,4 → reg1_o=4, reg2_o=rt data, alusel 010, aluop 7Ch.
